stage_fetch: RTL and testbench
==============================

// Module: stage_fetch
// PURPOSE
//   Instruction fetch stage of the vector ASIP pipeline; drives the IF side of Pipe_IF_ID.
//   Keeps the PC and reads a synchronous instruction memory (1-cycle read latency).
//   Presents one instruction/PC pair per cycle with a valid flag; holds it under a stall
//   (skid register); redirects on branch with wrong-path squash; stops on a HALT opcode.
// PARAMETERS
//   N           32      instruction width
//   PC_W        8       PC / imem address width (word addressed, +1 per instruction)
//   RESET_PC    0       PC loaded on reset
//   NOP_INSTR   32'h0   instruction driven when valid_o=0
//   HALT_OPCODE 4'hF    opcode (instr[N-1:N-4]) that halts fetch
// PORTS
//   CLK            in   1      clock, all state on rising edge
//   RST            in   1      synchronous reset, active-high
//   stall_i        in   1      downstream not accepting the presented instruction
//   redirect_i     in   1      branch taken; load target_i, squash fetched path
//   target_i       in   PC_W   redirect target PC
//   imem_addr_o    out  PC_W   imem read address; data returned next cycle
//   imem_data_i    in   N      imem read data for the previous cycle's imem_addr_o
//   instruction_o  out  N      instruction to Pipe_IF_ID (instruction_IF)
//   pc_o           out  PC_W   PC of instruction_o
//   valid_o        out  1      instruction_o is a real instruction
//   halted_o       out  1      fetch halted
//   instr_count_o  out  32     count of accepted instructions
// BEHAVIOUR
//   State regs: state, pc_q, fpc_q (PC of presented instr), hold_instr_q, hold_pc_q, cnt_q.
//   Reset (RST=1 at edge): state=BOOT, pc_q=RESET_PC, fpc_q/hold regs/cnt_q=0. During reset
//     and in BOOT: instruction_o=NOP_INSTR, pc_o=0, valid_o=0, halted_o=0, instr_count_o=0.
//     Reset mid-operation (any state) overrides all inputs; no held data survives.
//   imem_addr_o = pc_q combinationally in every state.
//   accept = valid_o & ~stall_i & ~redirect_i; cnt_q += 1 on accept (wraps at 2^32).
//   Priority per cycle: RST > redirect_i > stall_i > halt detect > advance.
//   BOOT: valid_o=0. redirect_i: pc_q<=target_i, stay BOOT. Else fpc_q<=pc_q,
//     pc_q<=pc_q+1, ->RUN (stall_i ignored in BOOT).
//   RUN: instruction_o=imem_data_i, pc_o=fpc_q, valid_o=1.
//     redirect_i: valid_o=0, instruction_o=NOP_INSTR this cycle; pc_q<=target_i; ->BOOT.
//     stall_i: hold_instr_q<=imem_data_i, hold_pc_q<=fpc_q; pc_q unchanged; ->HOLD.
//     opcode==HALT_OPCODE: HALT delivered (counted); pc_q unchanged; ->HALT.
//     else: fpc_q<=pc_q, pc_q<=pc_q+1, stay RUN.
//   HOLD: instruction_o=hold_instr_q, pc_o=hold_pc_q, valid_o=1.
//     redirect_i: as RUN (squash, ->BOOT). stall_i: stay HOLD, all unchanged.
//     release, held opcode==HALT_OPCODE: ->HALT. else fpc_q<=pc_q, pc_q<=pc_q+1, ->RUN
//     (imem_data_i next cycle is mem[pc_q] since address held at pc_q).
//   HALT: valid_o=0, instruction_o=NOP_INSTR, pc_o=fpc_q, halted_o=1; pc_q frozen;
//     stall_i ignored; only redirect_i (->BOOT, pc_q<=target_i) or RST leaves.
//   PC arithmetic modulo 2^PC_W: pc_q=2^PC_W-1 increments to 0, no flag.
//   Each instruction accepted exactly once; no skip/duplicate across stall/redirect.
//   First valid instruction after reset release: valid_o=1 on 2nd cycle (BOOT, then RUN).
// TESTING
//   T1 run: mem[k]=32'h1000_0000+k, no stall -> valid_o from 2nd cycle after RST drop,
//      pc_o=0,1,2.. with instruction_o=mem[pc_o] every cycle; count=10 after 10 accepts.
//   T2 stall: stall_i=1 for 3 cycles while pc_o=5 -> instruction_o=32'h1000_0005, pc_o=5
//      held 4 cycles total; pc_o=6 on cycle after release; count increments once for pc 5.
//   T3 redirect: redirect_i=1, target_i=8'h40 at pc_o=7 -> that cycle valid_o=0; next
//      cycle valid_o=0 (BOOT); then pc_o=8'h40, mem[8'h40]; pc 7 not counted.
//   T4 collision: redirect_i=1 and stall_i=1 same cycle in HOLD -> redirect wins, ->BOOT.
//   T5 halt: mem[3]=32'hF000_0000 -> pc_o=3 valid, then valid_o=0, halted_o=1, imem_addr_o
//      frozen 20 cycles; redirect to 0 -> halted_o=0, pc_o=0 two cycles later.
//   T6 wrap+reset: redirect to 8'hFF -> pc_o=FF then 00; assert RST during stall ->
//      next cycle valid_o=0, instr_count_o=0, imem_addr_o=RESET_PC.

Source files
------------

// File: rtl/stage_fetch.sv
// Instruction fetch stage: owns the PC, reads a synchronous instruction
// memory (data returns one cycle after the address) and presents one
// instruction/PC pair per cycle to the IF/ID pipe register.
//
// Handshake: valid_o marks instruction_o/pc_o as a real instruction. The pair
// is consumed on a cycle where valid_o=1, stall_i=0 and redirect_i=0. While
// stall_i=1 the same pair stays on the outputs. redirect_i squashes whatever
// is presented in that cycle and restarts fetch at target_i.
//
// FSM: BOOT -> RUN, with HOLD used as a skid state under stall and HALT
// entered after a HALT opcode is delivered.
module stage_fetch #(
   parameter int                N           = 32,
   parameter int                PC_W        = 8,
   parameter logic [PC_W-1:0]   RESET_PC    = '0,
   parameter logic [N-1:0]      NOP_INSTR   = '0,
   parameter logic [3:0]        HALT_OPCODE = 4'hF
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              stall_i,
   input  logic              redirect_i,
   input  logic [PC_W-1:0]   target_i,
   output logic [PC_W-1:0]   imem_addr_o,
   input  logic [N-1:0]      imem_data_i,
   output logic [N-1:0]      instruction_o,
   output logic [PC_W-1:0]   pc_o,
   output logic              valid_o,
   output logic              halted_o,
   output logic [31:0]       instr_count_o,
   output logic [1:0]        dbg_state_o
);

   typedef enum logic [1:0] {
      S_BOOT = 2'd0,
      S_RUN  = 2'd1,
      S_HOLD = 2'd2,
      S_HALT = 2'd3
   } state_t;

   localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

   state_t            r_state;
   logic [PC_W-1:0]   r_pc;          // address currently being read from imem
   logic [PC_W-1:0]   r_fpc;         // PC of the word imem returns this cycle
   logic [N-1:0]      r_hold_instr;  // skid copy of the stalled instruction
   logic [PC_W-1:0]   r_hold_pc;
   logic [31:0]       r_cnt;

   logic              w_valid;
   logic              w_accept;
   logic              w_run_halt;
   logic              w_hold_halt;
   logic [N-1:0]      w_instr;
   logic [PC_W-1:0]   w_pc;

   // The memory address is simply the PC register; imem data follows a cycle later.
   assign imem_addr_o = r_pc;

   // Opcode decode for the live word and for the held word.
   assign w_run_halt  = (imem_data_i[N-1 -: 4] == HALT_OPCODE);
   assign w_hold_halt = (r_hold_instr[N-1 -: 4] == HALT_OPCODE);

   // A redirect squashes the presented instruction in the same cycle; reset blanks everything.
   assign w_valid  = ~RST & ~redirect_i & ((r_state == S_RUN) | (r_state == S_HOLD));
   assign w_accept = w_valid & ~stall_i;

   // Select the presented instruction and its PC from the current state.
   always_comb begin
      w_instr = NOP_INSTR;
      w_pc    = '0;
      if (!RST) begin
         case (r_state)
            S_BOOT: begin
               w_instr = NOP_INSTR;
               w_pc    = '0;
            end
            S_RUN: begin
               w_instr = redirect_i ? NOP_INSTR : imem_data_i;
               w_pc    = r_fpc;
            end
            S_HOLD: begin
               w_instr = redirect_i ? NOP_INSTR : r_hold_instr;
               w_pc    = r_hold_pc;
            end
            S_HALT: begin
               w_instr = NOP_INSTR;
               w_pc    = r_fpc;
            end
            default: begin
               w_instr = NOP_INSTR;
               w_pc    = '0;
            end
         endcase
      end
   end

   assign instruction_o = w_instr;
   assign pc_o          = w_pc;
   assign valid_o       = w_valid;
   assign halted_o      = ~RST & (r_state == S_HALT);
   assign instr_count_o = RST ? 32'd0 : r_cnt;
   assign dbg_state_o   = r_state;

   // Fetch FSM, PC, skid register and accepted-instruction counter.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state      <= S_BOOT;
         r_pc         <= RESET_PC;
         r_fpc        <= '0;
         r_hold_instr <= '0;
         r_hold_pc    <= '0;
         r_cnt        <= '0;
      end else begin
         if (w_accept) begin
            r_cnt <= r_cnt + 32'd1;
         end
         case (r_state)
            S_BOOT: begin
               // Stall is meaningless here: nothing is presented yet.
               if (redirect_i) begin
                  r_pc <= target_i;
               end else begin
                  r_fpc   <= r_pc;
                  r_pc    <= r_pc + PC_ONE;
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               if (redirect_i) begin
                  r_pc    <= target_i;
                  r_state <= S_BOOT;
               end else if (stall_i) begin
                  // Capture the word now: imem data will change next cycle.
                  r_hold_instr <= imem_data_i;
                  r_hold_pc    <= r_fpc;
                  r_state      <= S_HOLD;
               end else if (w_run_halt) begin
                  r_state <= S_HALT;
               end else begin
                  r_fpc <= r_pc;
                  r_pc  <= r_pc + PC_ONE;
               end
            end
            S_HOLD: begin
               if (redirect_i) begin
                  r_pc    <= target_i;
                  r_state <= S_BOOT;
               end else if (stall_i) begin
                  r_state <= S_HOLD;
               end else if (w_hold_halt) begin
                  r_state <= S_HALT;
               end else begin
                  // The address sat at r_pc during the hold, so the next
                  // returned word is mem[r_pc] and belongs to r_fpc <= r_pc.
                  r_fpc   <= r_pc;
                  r_pc    <= r_pc + PC_ONE;
                  r_state <= S_RUN;
               end
            end
            S_HALT: begin
               if (redirect_i) begin
                  r_pc    <= target_i;
                  r_state <= S_BOOT;
               end
            end
            default: begin
               r_state <= S_BOOT;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_stage_fetch.sv
// Testbench for stage_fetch: synchronous imem model, scoreboard of expected
// accepted {pc, instruction} pairs, directed cycle checks and a random-stall run.
module tb_stage_fetch;

   logic          CLK;
   logic          RST;
   logic          stall_i;
   logic          redirect_i;
   logic [7:0]    target_i;
   logic [7:0]    imem_addr_o;
   logic [31:0]   imem_data_i;
   logic [31:0]   instruction_o;
   logic [7:0]    pc_o;
   logic          valid_o;
   logic          halted_o;
   logic [31:0]   instr_count_o;
   logic [1:0]    dbg_state_o;

   logic [31:0]   mem [256];
   logic [39:0]   exp_q [$];
   int            n_tests;
   int            n_fail;
   int            acc_n;

   stage_fetch dut (
      .CLK           (CLK),
      .RST           (RST),
      .stall_i       (stall_i),
      .redirect_i    (redirect_i),
      .target_i      (target_i),
      .imem_addr_o   (imem_addr_o),
      .imem_data_i   (imem_data_i),
      .instruction_o (instruction_o),
      .pc_o          (pc_o),
      .valid_o       (valid_o),
      .halted_o      (halted_o),
      .instr_count_o (instr_count_o),
      .dbg_state_o   (dbg_state_o)
   );

   // Clock / reset
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Synchronous instruction memory, one cycle read latency.
   always @(posedge CLK) imem_data_i <= mem[imem_addr_o];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Scoreboard: every accepted pair must match the head of the expected queue.
   always @(negedge CLK) begin
      logic [39:0] e;
      if (!RST && valid_o && !stall_i && !redirect_i) begin
         if (exp_q.size() == 0) begin
            check_eq("sb_underflow", exp_q.size(), 1);
         end else begin
            e = exp_q.pop_front();
            check_eq("sb_pc", {24'd0, pc_o}, {24'd0, e[39:32]});
            check_eq("sb_instr", instruction_o, e[31:0]);
         end
         acc_n++;
      end
   end

   // Driver: one clock cycle; inputs change just after posedge, caller samples after negedge.
   task automatic cyc(input logic r, input logic s, input logic d, input logic [7:0] t);
      @(posedge CLK);
      #1;
      RST        = r;
      stall_i    = s;
      redirect_i = d;
      target_i   = t;
      @(negedge CLK);
      #1;
   endtask

   task automatic push_exp(input logic [7:0] p);
      exp_q.push_back({p, mem[p]});
   endtask

   task automatic do_reset();
      cyc(1'b1, 1'b0, 1'b0, 8'h00);
      cyc(1'b1, 1'b0, 1'b0, 8'h00);
   endtask

   task automatic boot_cycle(input string tag);
      cyc(1'b0, 1'b0, 1'b0, 8'h00);
      check_eq(tag, {31'd0, valid_o}, 32'd0);
   endtask

   initial begin
      logic [7:0] p;
      n_tests    = 0;
      n_fail     = 0;
      acc_n      = 0;
      RST        = 1'b1;
      stall_i    = 1'b0;
      redirect_i = 1'b0;
      target_i   = 8'h00;
      for (int k = 0; k < 256; k++) mem[k] = 32'h1000_0000 + k;

      // T1: reset values, then straight-line run
      cyc(1'b1, 1'b0, 1'b0, 8'h00);
      check_eq("rst_valid", {31'd0, valid_o}, 32'd0);
      check_eq("rst_pc", {24'd0, pc_o}, 32'd0);
      check_eq("rst_instr", instruction_o, 32'h0);
      check_eq("rst_halted", {31'd0, halted_o}, 32'd0);
      check_eq("rst_count", instr_count_o, 32'd0);
      cyc(1'b1, 1'b0, 1'b0, 8'h00);
      check_eq("rst_addr", {24'd0, imem_addr_o}, 32'd0);
      for (int k = 0; k < 10; k++) push_exp(8'(k));
      boot_cycle("t1_boot_valid");
      check_eq("t1_boot_state", {30'd0, dbg_state_o}, 32'd0);
      for (int k = 0; k < 10; k++) begin
         cyc(1'b0, 1'b0, 1'b0, 8'h00);
         check_eq("t1_valid", {31'd0, valid_o}, 32'd1);
         check_eq("t1_pc", {24'd0, pc_o}, k);
      end
      cyc(1'b0, 1'b1, 1'b0, 8'h00);
      check_eq("t1_count", instr_count_o, 32'd10);
      check_eq("t1_next_pc", {24'd0, pc_o}, 32'd10);
      check_eq("t1_drain", exp_q.size(), 0);

      // T2: three stall cycles at pc 5
      do_reset();
      for (int k = 0; k < 7; k++) push_exp(8'(k));
      boot_cycle("t2_boot_valid");
      for (int k = 0; k < 5; k++) cyc(1'b0, 1'b0, 1'b0, 8'h00);
      for (int k = 0; k < 3; k++) begin
         cyc(1'b0, 1'b1, 1'b0, 8'h00);
         check_eq("t2_hold_pc", {24'd0, pc_o}, 32'd5);
         check_eq("t2_hold_instr", instruction_o, 32'h1000_0005);
         check_eq("t2_hold_valid", {31'd0, valid_o}, 32'd1);
         if (k > 0) check_eq("t2_hold_state", {30'd0, dbg_state_o}, 32'd2);
      end
      cyc(1'b0, 1'b0, 1'b0, 8'h00);
      check_eq("t2_release_pc", {24'd0, pc_o}, 32'd5);
      cyc(1'b0, 1'b0, 1'b0, 8'h00);
      check_eq("t2_after_pc", {24'd0, pc_o}, 32'd6);
      check_eq("t2_count_a", instr_count_o, 32'd6);
      cyc(1'b0, 1'b1, 1'b0, 8'h00);
      check_eq("t2_count_b", instr_count_o, 32'd7);
      check_eq("t2_drain", exp_q.size(), 0);

      // T3: redirect to 0x40 at pc 7
      do_reset();
      for (int k = 0; k < 7; k++) push_exp(8'(k));
      push_exp(8'h40);
      push_exp(8'h41);
      boot_cycle("t3_boot_valid");
      for (int k = 0; k < 7; k++) cyc(1'b0, 1'b0, 1'b0, 8'h00);
      cyc(1'b0, 1'b0, 1'b1, 8'h40);
      check_eq("t3_squash_valid", {31'd0, valid_o}, 32'd0);
      check_eq("t3_squash_instr", instruction_o, 32'h0);
      cyc(1'b0, 1'b0, 1'b0, 8'h00);
      check_eq("t3_boot_valid2", {31'd0, valid_o}, 32'd0);
      check_eq("t3_boot_addr", {24'd0, imem_addr_o}, 32'h40);
      cyc(1'b0, 1'b0, 1'b0, 8'h00);
      check_eq("t3_target_pc", {24'd0, pc_o}, 32'h40);
      check_eq("t3_target_instr", instruction_o, 32'h1000_0040);
      cyc(1'b0, 1'b0, 1'b0, 8'h00);
      cyc(1'b0, 1'b1, 1'b0, 8'h00);
      check_eq("t3_count", instr_count_o, 32'd9);
      check_eq("t3_drain", exp_q.size(), 0);

      // T4: redirect and stall together while in HOLD
      cyc(1'b0, 1'b1, 1'b1, 8'h80);
      check_eq("t4_valid", {31'd0, valid_o}, 32'd0);
      push_exp(8'h80);
      cyc(1'b0, 1'b0, 1'b0, 8'h00);
      check_eq("t4_boot_state", {30'd0, dbg_state_o}, 32'd0);
      check_eq("t4_boot_valid", {31'd0, valid_o}, 32'd0);
      check_eq("t4_addr", {24'd0, imem_addr_o}, 32'h80);
      cyc(1'b0, 1'b0, 1'b0, 8'h00);
      check_eq("t4_pc", {24'd0, pc_o}, 32'h80);
      cyc(1'b0, 1'b1, 1'b0, 8'h00);
      check_eq("t4_count", instr_count_o, 32'd10);
      check_eq("t4_drain", exp_q.size(), 0);

      // T5: HALT opcode at address 3
      mem[3] = 32'hF000_0000;
      do_reset();
      for (int k = 0; k < 4; k++) push_exp(8'(k));
      boot_cycle("t5_boot_valid");
      for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 1'b0, 8'h00);
      cyc(1'b0, 1'b0, 1'b0, 8'h00);
      check_eq("t5_halt_pc", {24'd0, pc_o}, 32'd3);
      check_eq("t5_halt_valid", {31'd0, valid_o}, 32'd1);
      for (int k = 0; k < 20; k++) begin
         cyc(1'b0, 1'($urandom_range(0, 1)), 1'b0, 8'h00);
         check_eq("t5_halted", {31'd0, halted_o}, 32'd1);
         check_eq("t5_valid", {31'd0, valid_o}, 32'd0);
         check_eq("t5_addr", {24'd0, imem_addr_o}, 32'd4);
         check_eq("t5_pc", {24'd0, pc_o}, 32'd3);
      end
      check_eq("t5_count_halt", instr_count_o, 32'd4);
      push_exp(8'h00);
      cyc(1'b0, 1'b0, 1'b1, 8'h00);
      check_eq("t5_redir_valid", {31'd0, valid_o}, 32'd0);
      cyc(1'b0, 1'b0, 1'b0, 8'h00);
      check_eq("t5_unhalted", {31'd0, halted_o}, 32'd0);
      cyc(1'b0, 1'b0, 1'b0, 8'h00);
      check_eq("t5_restart_pc", {24'd0, pc_o}, 32'd0);
      check_eq("t5_restart_valid", {31'd0, valid_o}, 32'd1);
      cyc(1'b0, 1'b1, 1'b0, 8'h00);
      check_eq("t5_count", instr_count_o, 32'd5);
      check_eq("t5_drain", exp_q.size(), 0);
      mem[3] = 32'h1000_0003;

      // T6: PC wrap, then reset asserted during a stall
      do_reset();
      cyc(1'b0, 1'b0, 1'b1, 8'hFF);
      check_eq("t6_boot_valid", {31'd0, valid_o}, 32'd0);
      push_exp(8'hFF);
      push_exp(8'h00);
      cyc(1'b0, 1'b0, 1'b0, 8'h00);
      check_eq("t6_addr_ff", {24'd0, imem_addr_o}, 32'hFF);
      cyc(1'b0, 1'b0, 1'b0, 8'h00);
      check_eq("t6_pc_ff", {24'd0, pc_o}, 32'hFF);
      check_eq("t6_instr_ff", instruction_o, 32'h1000_00FF);
      cyc(1'b0, 1'b0, 1'b0, 8'h00);
      check_eq("t6_pc_00", {24'd0, pc_o}, 32'h00);
      cyc(1'b0, 1'b1, 1'b0, 8'h00);
      check_eq("t6_pc_01", {24'd0, pc_o}, 32'h01);
      check_eq("t6_count", instr_count_o, 32'd2);
      cyc(1'b0, 1'b1, 1'b0, 8'h00);
      cyc(1'b1, 1'b1, 1'b0, 8'h00);
      check_eq("t6_rst_valid", {31'd0, valid_o}, 32'd0);
      cyc(1'b0, 1'b0, 1'b0, 8'h00);
      check_eq("t6_post_valid", {31'd0, valid_o}, 32'd0);
      check_eq("t6_post_count", instr_count_o, 32'd0);
      check_eq("t6_post_addr", {24'd0, imem_addr_o}, 32'd0);
      check_eq("t6_post_state", {30'd0, dbg_state_o}, 32'd0);
      check_eq("t6_drain", exp_q.size(), 0);

      // T7: random memory contents and random stalls, 40 in-order accepts
      for (int k = 0; k < 40; k++) mem[k] = 32'h2000_0000 | $urandom_range(0, 32'h0FFF_FFFF);
      do_reset();
      for (int k = 0; k < 40; k++) push_exp(8'(k));
      acc_n = 0;
      boot_cycle("t7_boot_valid");
      for (int i = 0; i < 400 && acc_n < 40; i++) begin
         cyc(1'b0, 1'($urandom_range(0, 2) == 0), 1'b0, 8'h00);
      end
      check_eq("t7_accepts", acc_n, 40);
      cyc(1'b0, 1'b1, 1'b0, 8'h00);
      p = pc_o;
      check_eq("t7_count", instr_count_o, 32'd40);
      check_eq("t7_next_pc", {24'd0, p}, 32'd40);
      check_eq("t7_drain", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
